atm_controller_gen: RTL
=======================

ATM_CONTROLLER_GEN -- requirements
Module: atm_controller_gen

Interface
REQ-001 Parameter PIN_DIGITS, 4, number of BCD digits in the PIN (1..8).
REQ-002 Parameter PIN_CORRECTO, 16'h4721, expected PIN as 4*PIN_DIGITS bits; first digit entered is the most significant nibble.
REQ-003 Parameter MAX_INTENTOS, 3, wrong-PIN count that causes lockout (2..7).
REQ-004 Parameter BALANCE_W, 64, balance register width.
REQ-005 Parameter MONTO_W, 32, amount width (MONTO_W <= BALANCE_W).
REQ-006 Parameter INIT_BALANCE, 4500, balance value loaded at reset.
REQ-007 Parameter LIMITE_RETIRO, 1000, per-transaction withdrawal limit (used only under REQ-027).
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-low.
REQ-010 tarjeta_recibida  in  1; tipo_trans  in  1 (1 = withdrawal, 0 = deposit); digito_stb  in  1; digito  in  4; monto_stb  in  1; monto  in  MONTO_W.
REQ-011 balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes  out  1 each, all registered; balance  out  BALANCE_W, registered.

Function
REQ-012 The FSM SHALL have states ESPERANDO_TARJETA, INGRESO_PIN, VERIFICAR_PIN, DEPOSITO, RETIRO and BLOQUEO.
REQ-013 ESPERANDO_TARJETA: when tarjeta_recibida=1, latch tipo_trans, clear the digit counter and PIN shift register, and go to INGRESO_PIN; the other inputs are ignored.
REQ-014 INGRESO_PIN: each cycle with digito_stb=1 and digito<=9 shifts digito into the PIN register and increments the digit counter; strobes with digito>9 are ignored.
REQ-015 On the PIN_DIGITS-th accepted digit, the FSM SHALL go to VERIFICAR_PIN on the next edge.
REQ-016 VERIFICAR_PIN SHALL last exactly one cycle.
REQ-017 Correct PIN: clear intento and advertencia, then go to RETIRO if the latched tipo_trans=1, otherwise DEPOSITO.
REQ-018 Wrong PIN: increment intento and pulse pin_incorrecto high for exactly one cycle.
REQ-019 Wrong PIN, continued: when intento reaches MAX_INTENTOS-1, set advertencia as a level; when intento reaches MAX_INTENTOS, go to BLOQUEO; otherwise return to INGRESO_PIN with the digit counter cleared.
REQ-020 BLOQUEO SHALL be absorbing: bloqueo=1 and all inputs ignored until reset.
REQ-021 DEPOSITO: on monto_stb=1, set balance to balance+monto, saturating at 2^BALANCE_W-1; pulse balance_actualizado for one cycle; return to ESPERANDO_TARJETA.
REQ-022 RETIRO: on monto_stb=1 with monto>balance, pulse fondos_insuficientes for one cycle, leave balance unchanged, and stay in RETIRO.
REQ-023 RETIRO: on monto_stb=1 with monto<=balance, set balance to balance-monto, pulse entregar_dinero and balance_actualizado together for one cycle, and return to ESPERANDO_TARJETA; monto=0 is a valid withdrawal.
REQ-024 Output pulses SHALL appear in the cycle after the deciding edge (one-cycle registered latency).
REQ-025 The intento count SHALL persist across card sessions; only a correct PIN or reset clears it.

Reset
REQ-026 While rst=0, regardless of clk: state=ESPERANDO_TARJETA, intento=0, digit counter=0, PIN register=0, balance=INIT_BALANCE, and all single-bit outputs=0; reset asserted mid-transaction SHALL abort it without altering the balance beyond INIT_BALANCE.

Configuration
REQ-027 With macro ATM_WITHDRAW_LIMIT_EN defined, a RETIRO strobe with monto>LIMITE_RETIRO SHALL be rejected exactly like REQ-022 (fondos_insuficientes pulse, stay in RETIRO), and the limit check SHALL take priority over the balance check.
REQ-028 With ATM_WITHDRAW_LIMIT_EN undefined, LIMITE_RETIRO SHALL be unused and only the balance check applies.

Verification
REQ-029 Reset release, card inserted with tipo_trans=0, digits 4,7,2,1, monto=500 strobed -> balance=5000, balance_actualizado pulses exactly 1 cycle, FSM in ESPERANDO_TARJETA.
REQ-030 Card with tipo_trans=1, correct PIN, monto=5000 -> fondos_insuficientes pulse and balance stays 4500; then monto=4500 -> entregar_dinero and balance_actualizado pulse together, balance=0.
REQ-031 Wrong PIN 1,1,1,1 three times -> pin_incorrecto pulses 3 times, advertencia=1 after the 2nd, bloqueo=1 after the 3rd; further cards are ignored until rst=0.
REQ-032 Digit stream 4,12,7,2,1 -> digit 12 is ignored and the PIN is accepted; one wrong PIN followed by a correct PIN -> intento=0 and advertencia=0.
REQ-033 BALANCE_W=8, INIT_BALANCE=250, deposit monto=10 -> balance=255 (saturated).
REQ-034 With ATM_WITHDRAW_LIMIT_EN defined, withdrawal of monto=1001 -> rejected with balance 4500; rst pulsed low between clock edges mid-PIN entry -> outputs cleared immediately.

Source files
------------

// File: rtl/atm_controller_gen_if.sv
// Card/keypad/amount request signals and registered ATM status outputs.
// The DUT attaches through the slave modport; a driver or bench uses master.
interface atm_controller_gen_if #(
    parameter int MONTO_W   = 32,
    parameter int BALANCE_W = 64
);
    logic                 tarjeta_recibida;
    logic                 tipo_trans;
    logic                 digito_stb;
    logic [3:0]           digito;
    logic                 monto_stb;
    logic [MONTO_W-1:0]   monto;
    logic                 balance_actualizado;
    logic                 entregar_dinero;
    logic                 pin_incorrecto;
    logic                 advertencia;
    logic                 bloqueo;
    logic                 fondos_insuficientes;
    logic [BALANCE_W-1:0] balance;

    modport slave (
        input  tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
        output balance_actualizado, entregar_dinero, pin_incorrecto, advertencia,
        output bloqueo, fondos_insuficientes, balance
    );

    modport master (
        output tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
        input  balance_actualizado, entregar_dinero, pin_incorrecto, advertencia,
        input  bloqueo, fondos_insuficientes, balance
    );
endinterface

// File: rtl/atm_controller_gen.sv
// ATM session controller: PIN entry with lockout, deposit and withdrawal on one balance.
// Optional ATM_WITHDRAW_LIMIT_EN adds a per-transaction withdrawal cap (LIMITE_RETIRO).
module atm_controller_gen #(
    parameter int                       PIN_DIGITS    = 4,
    parameter logic [4*PIN_DIGITS-1:0]  PIN_CORRECTO  = 16'h4721,
    parameter int                       MAX_INTENTOS  = 3,
    parameter int                       BALANCE_W     = 64,
    parameter int                       MONTO_W       = 32,
    parameter logic [BALANCE_W-1:0]     INIT_BALANCE  = BALANCE_W'(4500),
    parameter logic [MONTO_W-1:0]       LIMITE_RETIRO = MONTO_W'(1000)
) (
    input  logic clk,
    input  logic rst,
    atm_controller_gen_if.slave bus
);
    typedef enum logic [2:0] {
        ESPERANDO_TARJETA,
        INGRESO_PIN,
        VERIFICAR_PIN,
        DEPOSITO,
        RETIRO,
        BLOQUEO
    } state_t;

    localparam int          PIN_W    = 4 * PIN_DIGITS;
    localparam logic [3:0]  LAST_DIG = 4'(PIN_DIGITS - 1);
    localparam logic [2:0]  WARN_AT  = 3'(MAX_INTENTOS - 1);
    localparam logic [2:0]  LOCK_AT  = 3'(MAX_INTENTOS);
`ifdef ATM_WITHDRAW_LIMIT_EN
    localparam bit          LIMIT_EN = 1'b1;
`else
    localparam bit          LIMIT_EN = 1'b0;
`endif

    state_t               state;
    logic [3:0]           dig_cnt;
    logic [PIN_W-1:0]     pin_reg;
    logic [2:0]           intento;
    logic                 tipo_r;
    logic [BALANCE_W-1:0] balance_r;
    logic                 ba_r, ed_r, pi_r, adv_r, blq_r, fi_r;

    logic [BALANCE_W-1:0] monto_ext;
    logic [BALANCE_W:0]   suma;
    logic [BALANCE_W-1:0] dep_val;
    logic                 sin_fondos;
    logic                 sobre_limite;
    logic [2:0]           intento_inc;
    logic [PIN_W-1:0]     pin_shift;
    logic                 dig_ok;

    assign monto_ext    = BALANCE_W'(bus.monto);
    assign suma         = {1'b0, balance_r} + {1'b0, monto_ext};
    assign dep_val      = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
    assign sin_fondos   = monto_ext > balance_r;
    // Constant-false when the limit feature is compiled out, so only the balance check remains.
    assign sobre_limite = LIMIT_EN && (bus.monto > LIMITE_RETIRO);
    assign intento_inc  = intento + 3'd1;
    assign pin_shift    = (pin_reg << 4) | PIN_W'(bus.digito);
    assign dig_ok       = bus.digito_stb && (bus.digito <= 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ESPERANDO_TARJETA;
            dig_cnt   <= '0;
            pin_reg   <= '0;
            intento   <= '0;
            tipo_r    <= 1'b0;
            balance_r <= INIT_BALANCE;
            ba_r      <= 1'b0;
            ed_r      <= 1'b0;
            pi_r      <= 1'b0;
            adv_r     <= 1'b0;
            blq_r     <= 1'b0;
            fi_r      <= 1'b0;
        end else begin
            ba_r <= 1'b0;
            ed_r <= 1'b0;
            pi_r <= 1'b0;
            fi_r <= 1'b0;
            case (state)
                ESPERANDO_TARJETA: if (bus.tarjeta_recibida) begin
                    tipo_r  <= bus.tipo_trans;
                    dig_cnt <= '0;
                    pin_reg <= '0;
                    state   <= INGRESO_PIN;
                end
                INGRESO_PIN: if (dig_ok) begin
                    pin_reg <= pin_shift;
                    dig_cnt <= dig_cnt + 4'd1;
                    if (dig_cnt == LAST_DIG) state <= VERIFICAR_PIN;
                end
                VERIFICAR_PIN: begin
                    dig_cnt <= '0;
                    pin_reg <= '0;
                    if (pin_reg == PIN_CORRECTO) begin
                        intento <= '0;
                        adv_r   <= 1'b0;
                        state   <= tipo_r ? RETIRO : DEPOSITO;
                    end else begin
                        intento <= intento_inc;
                        pi_r    <= 1'b1;
                        if (intento_inc == WARN_AT) adv_r <= 1'b1;
                        if (intento_inc >= LOCK_AT) begin
                            blq_r <= 1'b1;
                            state <= BLOQUEO;
                        end else begin
                            state <= INGRESO_PIN;
                        end
                    end
                end
                DEPOSITO: if (bus.monto_stb) begin
                    balance_r <= dep_val;
                    ba_r      <= 1'b1;
                    state     <= ESPERANDO_TARJETA;
                end
                RETIRO: if (bus.monto_stb) begin
                    // Limit check wins over the balance check; both reject the same way.
                    if (sobre_limite || sin_fondos) begin
                        fi_r <= 1'b1;
                    end else begin
                        balance_r <= balance_r - monto_ext;
                        ed_r      <= 1'b1;
                        ba_r      <= 1'b1;
                        state     <= ESPERANDO_TARJETA;
                    end
                end
                BLOQUEO: blq_r <= 1'b1;
                default: state <= ESPERANDO_TARJETA;
            endcase
        end
    end

    assign bus.balance_actualizado  = ba_r;
    assign bus.entregar_dinero      = ed_r;
    assign bus.pin_incorrecto       = pi_r;
    assign bus.advertencia          = adv_r;
    assign bus.bloqueo              = blq_r;
    assign bus.fondos_insuficientes = fi_r;
    assign bus.balance              = balance_r;
endmodule
